// File: rtl/pong_pkg.sv
// Shared pong definitions: FSM state encoding and default screen and paddle geometry.
package pong_pkg;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_SERVE_WAIT = 2'd1,
        ST_PLAY       = 2'd2,
        ST_GAME_OVER  = 2'd3
    } state_t;

    localparam int DEF_COORD_W       = 16;
    localparam int DEF_SCREEN_WIDTH  = 640;
    localparam int DEF_PADDLE_HEIGHT = 80;
    localparam int DEF_PADDLE_MARGIN = 20;
    localparam int DEF_MAX_SCORE     = 9;
    localparam int DEF_SCORE_W       = 4;
    localparam int DEF_SERVE_DELAY   = 60;

endpackage

// File: rtl/score_counter.sv
// One player's score: synchronous clear, increment that saturates at max_score, at_max flag.
module score_counter #(
    parameter int SCORE_W   = 4,
    parameter int MAX_SCORE = 9
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clr,
    input  logic               inc,
    output logic [SCORE_W-1:0] score,
    output logic               at_max
);

    localparam logic [SCORE_W-1:0] MAX_VAL = SCORE_W'(MAX_SCORE);

    logic [SCORE_W-1:0] score_r;

    // Score register: clear wins over increment, increment stops at the maximum.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            score_r <= {SCORE_W{1'b0}};
        end else if (clr) begin
            score_r <= {SCORE_W{1'b0}};
        end else if (inc && (score_r != MAX_VAL)) begin
            score_r <= score_r + SCORE_W'(1);
        end else begin
            score_r <= score_r;
        end
    end

    assign score  = score_r;
    assign at_max = (score_r == MAX_VAL);

endmodule

// File: rtl/score_tracker.sv
// Pong game controller: serve delay, per-frame miss detection, scoring and game-over handling.
module score_tracker
    import pong_pkg::*;
#(
    parameter int COORD_W       = DEF_COORD_W,
    parameter int SCREEN_WIDTH  = DEF_SCREEN_WIDTH,
    parameter int PADDLE_HEIGHT = DEF_PADDLE_HEIGHT,
    parameter int PADDLE_MARGIN = DEF_PADDLE_MARGIN,
    parameter int MAX_SCORE     = DEF_MAX_SCORE,
    parameter int SCORE_W       = DEF_SCORE_W,
    parameter int SERVE_DELAY   = DEF_SERVE_DELAY
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               frame_tick,
    input  logic               start,
    input  logic               clear,
    input  logic [COORD_W-1:0] ball_x,
    input  logic [COORD_W-1:0] ball_y,
    input  logic [COORD_W-1:0] paddle1_y,
    input  logic [COORD_W-1:0] paddle2_y,
    output logic [SCORE_W-1:0] score1,
    output logic [SCORE_W-1:0] score2,
    output logic               point_p1,
    output logic               point_p2,
    output logic               ball_reset,
    output logic               serve_dir,
    output logic               game_over,
    output logic               winner,
    output logic [1:0]         state_o
);

    localparam int CNT_W = $clog2(SERVE_DELAY + 1);
    localparam int XW    = COORD_W + 1;

    localparam logic [CNT_W-1:0]   CNT_LAST  = CNT_W'(SERVE_DELAY - 1);
    localparam logic [SCORE_W-1:0] SCORE_PRE = SCORE_W'(MAX_SCORE - 1);
    localparam logic [XW-1:0]      X_P2_LO   = XW'(SCREEN_WIDTH - PADDLE_MARGIN);
    localparam logic [XW-1:0]      X_END     = XW'(SCREEN_WIDTH);
    localparam logic [XW-1:0]      X_P1_HI   = XW'(PADDLE_MARGIN);
    localparam logic [XW-1:0]      PAD_H     = XW'(PADDLE_HEIGHT);

    state_t             state_r, state_nxt_s;
    logic [CNT_W-1:0]   cnt_r, cnt_nxt_s;
    logic               point_p1_r, point_p1_nxt_s;
    logic               point_p2_r, point_p2_nxt_s;
    logic               ball_reset_r, ball_reset_nxt_s;
    logic               serve_dir_r, serve_dir_nxt_s;
    logic               game_over_r, game_over_nxt_s;
    logic               winner_r, winner_nxt_s;
    logic               inc1_s, inc2_s, sc_clr_s;
    logic               at_max1_s, at_max2_s;
    logic [SCORE_W-1:0] score1_s, score2_s;

    // Coordinates are widened by one bit so paddle_y + height cannot wrap.
    logic [XW-1:0] bx_s, by_s, p1_bot_s, p2_bot_s;
    logic          p1_miss_s, p2_miss_s;

    assign bx_s      = {1'b0, ball_x};
    assign by_s      = {1'b0, ball_y};
    assign p1_bot_s  = {1'b0, paddle1_y} + PAD_H;
    assign p2_bot_s  = {1'b0, paddle2_y} + PAD_H;
    assign p2_miss_s = (bx_s >= X_P2_LO) && (bx_s < X_END) &&
                       ((by_s < {1'b0, paddle2_y}) || (by_s >= p2_bot_s));
    assign p1_miss_s = (bx_s < X_P1_HI) &&
                       ((by_s < {1'b0, paddle1_y}) || (by_s >= p1_bot_s));

    score_counter #(.SCORE_W(SCORE_W), .MAX_SCORE(MAX_SCORE)) u_score1 (
        .clk(clk), .rst_n(rst_n), .clr(sc_clr_s), .inc(inc1_s),
        .score(score1_s), .at_max(at_max1_s)
    );

    score_counter #(.SCORE_W(SCORE_W), .MAX_SCORE(MAX_SCORE)) u_score2 (
        .clk(clk), .rst_n(rst_n), .clr(sc_clr_s), .inc(inc2_s),
        .score(score2_s), .at_max(at_max2_s)
    );

    // Next-state and next-output logic; clear overrides every state.
    always_comb begin
        state_nxt_s      = state_r;
        cnt_nxt_s        = cnt_r;
        point_p1_nxt_s   = 1'b0;
        point_p2_nxt_s   = 1'b0;
        ball_reset_nxt_s = 1'b0;
        serve_dir_nxt_s  = serve_dir_r;
        game_over_nxt_s  = game_over_r;
        winner_nxt_s     = winner_r;
        inc1_s           = 1'b0;
        inc2_s           = 1'b0;
        sc_clr_s         = 1'b0;
        if (clear) begin
            state_nxt_s     = ST_IDLE;
            cnt_nxt_s       = {CNT_W{1'b0}};
            game_over_nxt_s = 1'b0;
            sc_clr_s        = 1'b1;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        sc_clr_s        = 1'b1;
                        serve_dir_nxt_s = 1'b1;
                        cnt_nxt_s       = {CNT_W{1'b0}};
                        game_over_nxt_s = 1'b0;
                        state_nxt_s     = ST_SERVE_WAIT;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
                ST_SERVE_WAIT: begin
                    if (frame_tick && (cnt_r == CNT_LAST)) begin
                        cnt_nxt_s        = {CNT_W{1'b0}};
                        ball_reset_nxt_s = 1'b1;
                        state_nxt_s      = ST_PLAY;
                    end else if (frame_tick) begin
                        cnt_nxt_s = cnt_r + CNT_W'(1);
                    end else begin
                        cnt_nxt_s = cnt_r;
                    end
                end
                ST_PLAY: begin
                    // Simultaneous misses on both sides are ignored.
                    if (frame_tick && (p1_miss_s != p2_miss_s)) begin
                        cnt_nxt_s = {CNT_W{1'b0}};
                        if (p2_miss_s) begin
                            inc1_s          = !at_max1_s;
                            point_p1_nxt_s  = 1'b1;
                            serve_dir_nxt_s = 1'b1;
                            if (score1_s == SCORE_PRE) begin
                                state_nxt_s     = ST_GAME_OVER;
                                game_over_nxt_s = 1'b1;
                                winner_nxt_s    = 1'b0;
                            end else begin
                                state_nxt_s = ST_SERVE_WAIT;
                            end
                        end else begin
                            inc2_s          = !at_max2_s;
                            point_p2_nxt_s  = 1'b1;
                            serve_dir_nxt_s = 1'b0;
                            if (score2_s == SCORE_PRE) begin
                                state_nxt_s     = ST_GAME_OVER;
                                game_over_nxt_s = 1'b1;
                                winner_nxt_s    = 1'b1;
                            end else begin
                                state_nxt_s = ST_SERVE_WAIT;
                            end
                        end
                    end else begin
                        state_nxt_s = ST_PLAY;
                    end
                end
                ST_GAME_OVER: begin
                    if (start) begin
                        sc_clr_s        = 1'b1;
                        game_over_nxt_s = 1'b0;
                        serve_dir_nxt_s = ~winner_r;
                        cnt_nxt_s       = {CNT_W{1'b0}};
                        state_nxt_s     = ST_SERVE_WAIT;
                    end else begin
                        state_nxt_s = ST_GAME_OVER;
                    end
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                    cnt_nxt_s   = {CNT_W{1'b0}};
                end
            endcase
        end
    end

    // State, delay counter and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            cnt_r        <= {CNT_W{1'b0}};
            point_p1_r   <= 1'b0;
            point_p2_r   <= 1'b0;
            ball_reset_r <= 1'b0;
            serve_dir_r  <= 1'b1;
            game_over_r  <= 1'b0;
            winner_r     <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            cnt_r        <= cnt_nxt_s;
            point_p1_r   <= point_p1_nxt_s;
            point_p2_r   <= point_p2_nxt_s;
            ball_reset_r <= ball_reset_nxt_s;
            serve_dir_r  <= serve_dir_nxt_s;
            game_over_r  <= game_over_nxt_s;
            winner_r     <= winner_nxt_s;
        end
    end

    assign score1     = score1_s;
    assign score2     = score2_s;
    assign point_p1   = point_p1_r;
    assign point_p2   = point_p2_r;
    assign ball_reset = ball_reset_r;
    assign serve_dir  = serve_dir_r;
    assign game_over  = game_over_r;
    assign winner     = winner_r;
    assign state_o    = state_r;

endmodule

// File: tb/tb_score_tracker.sv
// Directed self-checking bench for score_tracker with default parameters.
module tb_score_tracker;

    logic        clk;
    logic        rst_n;
    logic        frame_tick;
    logic        start;
    logic        clear;
    logic [15:0] ball_x, ball_y, paddle1_y, paddle2_y;
    logic [3:0]  score1, score2;
    logic        point_p1, point_p2, ball_reset, serve_dir, game_over, winner;
    logic [1:0]  state_o;

    int n_checks;
    int n_errors;
    int br_cnt;
    int p1_cnt;
    int p2_cnt;
    int snap;

    score_tracker dut (
        .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .start(start), .clear(clear),
        .ball_x(ball_x), .ball_y(ball_y), .paddle1_y(paddle1_y), .paddle2_y(paddle2_y),
        .score1(score1), .score2(score2), .point_p1(point_p1), .point_p2(point_p2),
        .ball_reset(ball_reset), .serve_dir(serve_dir), .game_over(game_over),
        .winner(winner), .state_o(state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (obs !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input logic ft);
        frame_tick = ft;
        @(posedge clk);
        #1;
        frame_tick = 1'b0;
        br_cnt = br_cnt + int'(ball_reset);
        p1_cnt = p1_cnt + int'(point_p1);
        p2_cnt = p2_cnt + int'(point_p2);
    endtask

    task automatic park();
        ball_x = 16'd300;
        ball_y = 16'd300;
    endtask

    task automatic to_play();
        park();
        for (int i = 0; i < 200 && state_o != 2'd2; i++) step(1'b1);
        check("to_play", 32'(state_o), 32'd2);
    endtask

    // One PLAY-state tick at a position; expects a P1 point or none.
    task automatic try_p2_miss(input string tag, input logic [15:0] x, input logic [15:0] y,
                               input logic exp_pt);
        ball_x = x;
        ball_y = y;
        step(1'b1);
        check(tag, 32'(point_p1), 32'(exp_pt));
        if (point_p1) to_play();
    endtask

    initial begin
        n_checks = 0; n_errors = 0; br_cnt = 0; p1_cnt = 0; p2_cnt = 0;
        rst_n = 1'b0; frame_tick = 1'b0; start = 1'b0; clear = 1'b0;
        ball_x = 16'd300; ball_y = 16'd300; paddle1_y = 16'd200; paddle2_y = 16'd100;
        @(posedge clk); #1;
        check("rst_state", 32'(state_o), 32'd0);
        check("rst_score1", 32'(score1), 32'd0);
        check("rst_score2", 32'(score2), 32'd0);
        check("rst_serve_dir", 32'(serve_dir), 32'd1);
        check("rst_game_over", 32'(game_over), 32'd0);
        check("rst_ball_reset", 32'(ball_reset), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Start and 60-tick serve delay
        start = 1'b1;
        step(1'b0);
        start = 1'b0;
        check("start_state", 32'(state_o), 32'd1);
        for (int i = 0; i < 59; i++) step(1'b1);
        check("serve59_state", 32'(state_o), 32'd1);
        check("serve59_br", 32'(br_cnt), 32'd0);
        step(1'b1);
        check("serve60_br_pulse", 32'(ball_reset), 32'd1);
        check("serve60_state", 32'(state_o), 32'd2);
        check("serve60_dir", 32'(serve_dir), 32'd1);
        step(1'b0);
        check("br_single", 32'(br_cnt), 32'd1);

        // No detection without frame_tick
        ball_x = 16'd625; ball_y = 16'd300;
        step(1'b0);
        check("no_tick_no_point", 32'(point_p1), 32'd0);

        // P2 miss scores for P1, only once per serve
        step(1'b1);
        check("p2miss_pulse", 32'(point_p1), 32'd1);
        check("p2miss_score1", 32'(score1), 32'd1);
        check("p2miss_dir", 32'(serve_dir), 32'd1);
        check("p2miss_state", 32'(state_o), 32'd1);
        for (int i = 0; i < 5; i++) step(1'b1);
        check("one_point_per_serve", 32'(p1_cnt), 32'd1);
        check("score1_hold", 32'(score1), 32'd1);

        // Boundaries around paddle2_y=100
        to_play();
        try_p2_miss("y99_scores", 16'd625, 16'd99, 1'b1);
        try_p2_miss("y180_scores", 16'd625, 16'd180, 1'b1);
        try_p2_miss("y100_safe", 16'd625, 16'd100, 1'b0);
        try_p2_miss("y179_safe", 16'd625, 16'd179, 1'b0);
        try_p2_miss("x619_safe", 16'd619, 16'd300, 1'b0);
        try_p2_miss("x640_safe", 16'd640, 16'd300, 1'b0);
        check("boundary_score1", 32'(score1), 32'd3);

        // Paddle near top of coordinate range: no wrap of paddle1_y+80
        paddle1_y = 16'd65500;
        ball_x = 16'd5; ball_y = 16'd65535;
        step(1'b1);
        check("p1_nowrap_safe", 32'(point_p2), 32'd0);
        ball_y = 16'd0;
        step(1'b1);
        check("p1_y0_scores", 32'(point_p2), 32'd1);
        check("p1_y0_score2", 32'(score2), 32'd1);
        check("p1_miss_dir", 32'(serve_dir), 32'd0);

        // Bring score2 to 8, then the winning point
        paddle1_y = 16'd200;
        for (int k = 0; k < 7; k++) begin
            to_play();
            ball_x = 16'd5; ball_y = 16'd0;
            step(1'b1);
        end
        check("score2_eight", 32'(score2), 32'd8);
        to_play();
        snap = br_cnt;
        ball_x = 16'd5; ball_y = 16'd0;
        step(1'b1);
        check("win_score2", 32'(score2), 32'd9);
        check("win_game_over", 32'(game_over), 32'd1);
        check("win_winner", 32'(winner), 32'd1);
        check("win_state", 32'(state_o), 32'd3);
        for (int i = 0; i < 70; i++) step(1'b1);
        check("gameover_no_br", 32'(br_cnt - snap), 32'd0);
        check("gameover_hold", 32'(score2), 32'd9);
        start = 1'b1;
        step(1'b0);
        start = 1'b0;
        check("restart_score1", 32'(score1), 32'd0);
        check("restart_score2", 32'(score2), 32'd0);
        check("restart_dir", 32'(serve_dir), 32'd0);
        check("restart_state", 32'(state_o), 32'd1);
        check("restart_go", 32'(game_over), 32'd0);

        // Clear and start together mid-serve: clear wins
        to_play();
        try_p2_miss("pre_clear_point", 16'd625, 16'd0, 1'b1);
        ball_x = 16'd625; ball_y = 16'd0;
        for (int i = 0; i < 3; i++) step(1'b1);
        clear = 1'b1; start = 1'b1;
        step(1'b0);
        clear = 1'b0; start = 1'b0;
        check("clear_state", 32'(state_o), 32'd0);
        check("clear_score1", 32'(score1), 32'd0);

        // Async reset right after a point pulse
        start = 1'b1;
        step(1'b0);
        start = 1'b0;
        to_play();
        ball_x = 16'd5; ball_y = 16'd0;
        step(1'b1);
        check("pre_rst_pulse", 32'(point_p2), 32'd1);
        rst_n = 1'b0;
        #1;
        check("arst_pulse", 32'(point_p2), 32'd0);
        check("arst_score2", 32'(score2), 32'd0);
        check("arst_state", 32'(state_o), 32'd0);
        check("arst_dir", 32'(serve_dir), 32'd1);
        snap = br_cnt + p1_cnt + p2_cnt;
        for (int i = 0; i < 3; i++) step(1'b1);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) step(1'b1);
        check("post_rst_no_pulse", 32'(br_cnt + p1_cnt + p2_cnt - snap), 32'd0);
        check("post_rst_idle", 32'(state_o), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
